i2c_target_receiver: RTL and testbench
======================================

# i2c_target_receiver

Write-only I2C target (slave) that sits on the same two-wire bus as the team's I2C controller and receives its writes. Oversamples SCL/SDA on the system Clock, detects START/STOP, matches a 7-bit address, drives ACK by pulling SDA low, and presents each received data byte with a one-cycle valid strobe. Reads are not supported and are NACKed.

## Interface
- ADDRESS, 7'h27, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (min 2).
- Clock  in  1  system clock; must be ≥ 8× the SCL rate.
- Reset  in  1  asynchronous, active-high.
- SCL  in  1  bus clock as seen at the pin (asynchronous).
- SDAIn  in  1  bus data as seen at the pin (asynchronous).
- SDAPullLow  out  1  1 = drive SDA low (open-drain enable); 0 = release.
- DataOut  out  8  last received data byte, MSB first on the bus.
- DataValid  out  1  one-Clock pulse when DataOut updates.
- AddressMatch  out  1  high from the matched address ACK until STOP or repeated START.
- Busy  out  1  high whenever the state is not Idle.

## Operation
- Reset drives state Idle, bit counter 0, shift register 0; SDAPullLow, DataValid, AddressMatch, Busy = 0; DataOut = 8'h00.
- Events, computed from synchronized samples s (current) and p (previous Clock):
  - SclRise: SCL p=0, s=1. SclFall: SCL p=1, s=0.
  - Start: SCL high in p and s, SDA p=1, s=0. Stop: SCL high in p and s, SDA p=0, s=1.
  - SCL and SDA changing in the same sample: SCL edge only, never Start/Stop.
- States: Idle, Address, AddrAck, Data, DataAck, Ignore.
- Start in any state → Address, counter 0, SDAPullLow 0, AddressMatch 0 (repeated START identical to START).
- Stop in any state → Idle, SDAPullLow 0, AddressMatch 0.
- Address: shift SDA in on each SclRise, counter +1. On the SclFall after the 8th bit:
  - address == ADDRESS and R/W = 0: go to AddrAck, set SDAPullLow = 1 and AddressMatch = 1.
  - otherwise (mismatch, R/W = 1, or general call 7'h00): go to Ignore with SDAPullLow = 0.
- AddrAck: on the next SclFall, release SDA, counter 0, go to Data.
- Data: shift on SclRise. On the SclFall after the 8th bit, load DataOut, pulse DataValid, set SDAPullLow = 1, and go to DataAck.
- DataAck: on the next SclFall, release SDA, counter 0, go back to Data.
- Ignore: SDAPullLow held 0; leave only on Start or Stop.
- Counter is 4 bits and saturates at 8; extra SclRise in Address/Data is not possible before the ACK SclFall.

## Timing
- Pin-to-event latency: SYNC_STAGES + 1 Clock cycles.
- SDAPullLow changes on the Clock edge that registers the triggering SclFall, which is within SCL-low time, so SDA never changes while SCL is high.
- DataValid is high for exactly one Clock. DataOut is stable from that edge until the next byte's valid edge.
- Stop during DataAck or AddrAck: release on the same edge that detects Stop.
- Stop mid-byte: partial byte discarded with no DataValid.
- Reset mid-ACK: SDAPullLow falls asynchronously.

## Structure
- Shared package i2c_pkg: state enumeration, ACK = 0 / NACK = 1 constants, default ADDRESS, and the general-call address constant.
- One sub-module, i2c_line_sync: SYNC_STAGES synchronizer plus previous-sample register. It outputs the synced level, rise, and fall, and is instanced once for SCL and once for SDA. The top-level block contains the event decode, FSM, counter, and shift register.

## Test plan
- START, address 0x27+W (byte 0x4E), ACK slot, data 0xA5, ACK slot, STOP → SDAPullLow = 1 during both ACK slots, DataOut = 0xA5, one DataValid pulse, then Busy = 0.
- START, 0x50 (address 0x28+W), then 0x11 → SDAPullLow stays 0 throughout, no DataValid, AddressMatch = 0.
- START, 0x4F (0x27+R) → NACK (SDAPullLow = 0), state Ignore until STOP.
- START, 0x4E, 0x3C, repeated START, 0x4E, 0xC3, STOP → two DataValid pulses with 0x3C then 0xC3, and AddressMatch drops for the repeated START.
- STOP after 4 bits of a data byte → no DataValid, DataOut keeps its previous value, state Idle.
- Reset asserted during the data ACK slot → SDAPullLow = 0 immediately; the next START+0x4E is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and addresses.
package i2c_pkg;

    typedef enum logic [2:0] {
        Idle,
        Address,
        AddrAck,
        Data,
        DataAck,
        Ignore
    } i2cState_t;

    // Bus levels of the ninth (acknowledge) bit.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'h27;
    localparam logic [6:0] GENERAL_CALL    = 7'h00;

    localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes one asynchronous bus line and reports its level and edges.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic LineIn,
    output logic Level,
    output logic Rise,
    output logic Fall
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevReg;

    // Synchronizer chain plus previous-sample register; reset to the idle
    // (released, pulled-up) bus level so no spurious edges follow reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            syncReg <= '1;
            prevReg <= 1'b1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], LineIn};
            prevReg <= syncReg[SYNC_STAGES-1];
        end
    end

    assign Level = syncReg[SYNC_STAGES-1];
    assign Rise  = Level & ~prevReg;
    assign Fall  = ~Level & prevReg;

endmodule

// File: rtl/i2c_target_receiver.sv
// Write-only I2C target: address match, ACK generation and byte delivery.
module i2c_target_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = DEFAULT_ADDRESS,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDAIn,
    output logic       SDAPullLow,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       AddressMatch,
    output logic       Busy
);

    logic sclLevel, sclRise, sclFall;
    logic sdaLevel, sdaRise, sdaFall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uSclSync (
        .Clock (Clock),
        .Reset (Reset),
        .LineIn(SCL),
        .Level (sclLevel),
        .Rise  (sclRise),
        .Fall  (sclFall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uSdaSync (
        .Clock (Clock),
        .Reset (Reset),
        .LineIn(SDAIn),
        .Level (sdaLevel),
        .Rise  (sdaRise),
        .Fall  (sdaFall)
    );

    // SCL high in both samples; an SCL edge in the same sample as an SDA
    // edge therefore never qualifies as START/STOP.
    logic sclHeld;
    logic startEv, stopEv;
    assign sclHeld = sclLevel & ~sclRise;
    assign startEv = sclHeld & sdaFall;
    assign stopEv  = sclHeld & sdaRise;

    i2cState_t  state, stateNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftNext;
    logic [7:0] dataNext;
    logic       validNext, pullNext, matchNext;

    // Address byte accepted only for our address with write direction; the
    // general-call address is never claimed.
    logic addrHit;
    assign addrHit = (shiftReg[7:1] == ADDRESS) && (shiftReg[0] == 1'b0) &&
                     (shiftReg[7:1] != GENERAL_CALL);

    // State and datapath registers; outputs are registered so SDAPullLow
    // moves only on the edge that registers an SCL fall.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= Idle;
            bitCnt       <= 4'd0;
            shiftReg     <= 8'h00;
            DataOut      <= 8'h00;
            DataValid    <= 1'b0;
            SDAPullLow   <= 1'b0;
            AddressMatch <= 1'b0;
        end else begin
            state        <= stateNext;
            bitCnt       <= bitCntNext;
            shiftReg     <= shiftNext;
            DataOut      <= dataNext;
            DataValid    <= validNext;
            SDAPullLow   <= pullNext;
            AddressMatch <= matchNext;
        end
    end

    // Next-state logic: bus conditions override everything, then per-state
    // bit shifting on SCL rise and ACK handling on SCL fall.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        dataNext   = DataOut;
        validNext  = 1'b0;
        pullNext   = SDAPullLow;
        matchNext  = AddressMatch;

        if (startEv) begin
            stateNext  = Address;
            bitCntNext = 4'd0;
            pullNext   = 1'b0;
            matchNext  = 1'b0;
        end else if (stopEv) begin
            stateNext = Idle;
            pullNext  = 1'b0;
            matchNext = 1'b0;
        end else begin
            case (state)
                Address, Data: begin
                    if (sclRise && bitCnt != BYTE_BITS) begin
                        shiftNext  = {shiftReg[6:0], sdaLevel};
                        bitCntNext = bitCnt + 4'd1;
                    end else if (sclFall && bitCnt == BYTE_BITS) begin
                        if (state == Data) begin
                            dataNext  = shiftReg;
                            validNext = 1'b1;
                            pullNext  = ~ACK;
                            stateNext = DataAck;
                        end else if (addrHit) begin
                            pullNext  = ~ACK;
                            matchNext = 1'b1;
                            stateNext = AddrAck;
                        end else begin
                            pullNext  = ~NACK;
                            stateNext = Ignore;
                        end
                    end
                end
                AddrAck, DataAck: begin
                    if (sclFall) begin
                        pullNext   = 1'b0;
                        bitCntNext = 4'd0;
                        stateNext  = Data;
                    end
                end
                Ignore: pullNext = 1'b0;
                default: ;
            endcase
        end
    end

    assign Busy = (state != Idle);

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Self-checking bench: bit-banged I2C controller with a byte scoreboard.
module tb_i2c_target_receiver;

    localparam int Q = 4;  // Clock cycles per quarter SCL period

    logic       Clock  = 1'b0;
    logic       Reset  = 1'b1;
    logic       SCL    = 1'b1;
    logic       sdaDrv = 1'b1;
    logic       SDAIn;
    logic       SDAPullLow;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       AddressMatch;
    logic       Busy;

    // Open-drain bus: either side may pull low.
    assign SDAIn = sdaDrv & ~SDAPullLow;

    i2c_target_receiver #(.ADDRESS(7'h27), .SYNC_STAGES(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SCL         (SCL),
        .SDAIn       (SDAIn),
        .SDAPullLow  (SDAPullLow),
        .DataOut     (DataOut),
        .DataValid   (DataValid),
        .AddressMatch(AddressMatch),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] expQ[$];
    logic [7:0] lastByte = 8'h00;
    logic       pullSeen = 1'b0;
    logic       prevValid = 1'b0;
    logic       prevPull = 1'b0;
    logic       prevScl = 1'b1;

    // Scoreboard monitor plus bus-protocol checks.
    always @(negedge Clock) begin
        logic [7:0] exp;
        if (DataValid) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: DataOut=%h, no byte expected", DataOut);
            end else begin
                exp = expQ.pop_front();
                lastByte = exp;
                if (DataOut !== exp) begin
                    bad++;
                    $display("FAIL data_byte: got %h expected %h", DataOut, exp);
                end
            end
            total++;
            if (prevValid) begin
                bad++;
                $display("FAIL valid_width: DataValid high %0d cycles, expected 1", 2);
            end
        end
        if (SDAPullLow) pullSeen = 1'b1;
        if (SCL && prevScl) begin
            total++;
            if (SDAPullLow !== prevPull) begin
                bad++;
                $display("FAIL sda_stable: SDAPullLow %b->%b while SCL high", prevPull, SDAPullLow);
            end
        end
        prevValid = DataValid;
        prevPull  = SDAPullLow;
        prevScl   = SCL;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    // START from idle, or repeated START from SCL low.
    task automatic busStart();
        sdaDrv = 1'b1; tick(Q);
        SCL = 1'b1;    tick(Q);
        sdaDrv = 1'b0; tick(Q);
        SCL = 1'b0;    tick(Q);
    endtask

    task automatic busStop();
        sdaDrv = 1'b0; tick(Q);
        SCL = 1'b1;    tick(Q);
        sdaDrv = 1'b1; tick(Q);
    endtask

    task automatic writeBit(input logic b);
        sdaDrv = b;    tick(Q);
        SCL = 1'b1;    tick(2 * Q);
        SCL = 1'b0;    tick(Q);
    endtask

    task automatic ackSlot(output logic ack);
        sdaDrv = 1'b1; tick(Q);
        SCL = 1'b1;    tick(Q);
        ack = ~SDAIn;  tick(Q);
        SCL = 1'b0;    tick(Q);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic push, input logic expAck,
                            input string name);
        logic ack;
        if (push) expQ.push_back(b);
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        ackSlot(ack);
        total++;
        if (ack !== expAck) begin
            bad++;
            $display("FAIL %s: ack=%b expected %b (byte %h)", name, ack, expAck, b);
        end
    endtask

    task automatic test_reset();
        tick(3);
        total++;
        if ({SDAPullLow, DataValid, AddressMatch, Busy} !== 4'b0000 || DataOut !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: pull=%b valid=%b match=%b busy=%b data=%h expected all 0",
                     SDAPullLow, DataValid, AddressMatch, Busy, DataOut);
        end
        Reset = 1'b0;
        tick(4);
    endtask

    task automatic test_write();
        busStart();
        sendByte(8'h4E, 1'b0, 1'b1, "write_addr_ack");
        total++;
        if (AddressMatch !== 1'b1) begin
            bad++;
            $display("FAIL write_match: AddressMatch=%b expected 1", AddressMatch);
        end
        sendByte(8'hA5, 1'b1, 1'b1, "write_data_ack");
        busStop();
        tick(Q);
        total++;
        if (Busy !== 1'b0 || DataOut !== 8'hA5 || AddressMatch !== 1'b0) begin
            bad++;
            $display("FAIL write_end: busy=%b data=%h match=%b expected 0/a5/0",
                     Busy, DataOut, AddressMatch);
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL write_drain: %0d bytes pending expected 0", expQ.size());
        end
    endtask

    task automatic test_mismatch();
        pullSeen = 1'b0;
        busStart();
        sendByte(8'h50, 1'b0, 1'b0, "mismatch_addr_nack");
        total++;
        if (AddressMatch !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_match: AddressMatch=%b expected 0", AddressMatch);
        end
        sendByte(8'h11, 1'b0, 1'b0, "mismatch_data_nack");
        busStop();
        tick(Q);
        total++;
        if (pullSeen !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_quiet: pullSeen=%b busy=%b expected 0/0", pullSeen, Busy);
        end
    endtask

    task automatic test_read_nack();
        pullSeen = 1'b0;
        busStart();
        sendByte(8'h4F, 1'b0, 1'b0, "read_addr_nack");
        for (int i = 0; i < 5; i++) writeBit(i[0]);
        total++;
        if (Busy !== 1'b1 || AddressMatch !== 1'b0 || pullSeen !== 1'b0) begin
            bad++;
            $display("FAIL read_ignore: busy=%b match=%b pullSeen=%b expected 1/0/0",
                     Busy, AddressMatch, pullSeen);
        end
        busStop();
        tick(Q);
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL read_idle: busy=%b expected 0", Busy);
        end
    endtask

    task automatic test_back_to_back();
        busStart();
        sendByte(8'h4E, 1'b0, 1'b1, "rs_addr1_ack");
        sendByte(8'h3C, 1'b1, 1'b1, "rs_data1_ack");
        busStart();
        total++;
        if (AddressMatch !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL rs_match_drop: match=%b busy=%b expected 0/1", AddressMatch, Busy);
        end
        sendByte(8'h4E, 1'b0, 1'b1, "rs_addr2_ack");
        sendByte(8'hC3, 1'b1, 1'b1, "rs_data2_ack");
        busStop();
        tick(Q);
        total++;
        if (expQ.size() != 0 || DataOut !== 8'hC3) begin
            bad++;
            $display("FAIL rs_end: pending=%0d data=%h expected 0/c3", expQ.size(), DataOut);
        end
    endtask

    task automatic test_stop_midbyte();
        busStart();
        sendByte(8'h4E, 1'b0, 1'b1, "mid_addr_ack");
        sendByte(8'h77, 1'b1, 1'b1, "mid_data_ack");
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b0);
        busStop();
        tick(Q);
        total++;
        if (DataOut !== lastByte || Busy !== 1'b0 || lastByte !== 8'h77) begin
            bad++;
            $display("FAIL mid_stop: data=%h busy=%b expected %h/0", DataOut, Busy, 8'h77);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] b;
        busStart();
        sendByte(8'h4E, 1'b0, 1'b1, "rst_addr_ack");
        b = 8'h5A;
        expQ.push_back(b);
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        sdaDrv = 1'b1;
        total++;
        if (SDAPullLow !== 1'b1) begin
            bad++;
            $display("FAIL rst_ack_driven: SDAPullLow=%b expected 1", SDAPullLow);
        end
        #3;
        Reset = 1'b1;
        lastByte = 8'h00;
        #1;
        total++;
        if (SDAPullLow !== 1'b0 || Busy !== 1'b0 || AddressMatch !== 1'b0 || DataOut !== 8'h00) begin
            bad++;
            $display("FAIL rst_async: pull=%b busy=%b match=%b data=%h expected 0/0/0/00",
                     SDAPullLow, Busy, AddressMatch, DataOut);
        end
        tick(4);
        Reset = 1'b0;
        tick(4);
        busStop();
        busStart();
        sendByte(8'h4E, 1'b0, 1'b1, "rst_readdr_ack");
        total++;
        if (AddressMatch !== 1'b1) begin
            bad++;
            $display("FAIL rst_rematch: AddressMatch=%b expected 1", AddressMatch);
        end
        busStop();
        tick(Q);
        total++;
        if (expQ.size() != 0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_end: pending=%0d busy=%b expected 0/0", expQ.size(), Busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read_nack();
        test_back_to_back();
        test_stop_midbyte();
        test_reset_mid_ack();
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
